// File: rtl/pin_seq_ctrl.sv
// Two-nibble PIN entry controller: checks the entry against a stored PIN,
// counts wrong attempts into a timed lockout, and allows reprogramming after a good entry.
module pin_seq_ctrl #(
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned HOLD_CYC    = 8,
    parameter int unsigned LOCK_CYC    = 16,
    parameter int unsigned TIMEOUT_CYC = 32,
    parameter logic [7:0]  DEFAULT_PIN = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_nibble,
    input  logic       prog_en,
    output logic       req_access,
    output logic [7:0] pin,
    output logic       first_four_match,
    output logic       last_four_match,
    output logic       busy,
    output logic       locked_out,
    output logic [2:0] tries_left,
    output logic       pin_updated,
    output logic [2:0] state_dbg
);

    // key_valid is a one-cycle strobe with no back-pressure: a nibble is taken
    // only by a state that accepts keys; in any other state it is dropped.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_LO  = 3'd1,
        CHECK   = 3'd2,
        HOLD    = 3'd3,
        LOCKOUT = 3'd4,
        PROG_HI = 3'd5,
        PROG_LO = 3'd6
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0] HOLD_LAST    = 16'(HOLD_CYC - 1);
    localparam logic [15:0] LOCK_LAST    = 16'(LOCK_CYC - 1);
    localparam logic [2:0]  TRIES_INIT   = 3'(MAX_TRIES);

    state_t      state;
    logic [15:0] cnt;
    logic [7:0]  stored_pin;
    logic [3:0]  shadow_hi;

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            stored_pin       <= DEFAULT_PIN;
            shadow_hi        <= '0;
            req_access       <= 1'b0;
            pin              <= '0;
            first_four_match <= 1'b0;
            last_four_match  <= 1'b0;
            busy             <= 1'b0;
            locked_out       <= 1'b0;
            tries_left       <= TRIES_INIT;
            pin_updated      <= 1'b0;
        end else begin
            req_access  <= 1'b0;
            pin_updated <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        pin[7:4]         <= key_nibble;
                        first_four_match <= 1'b0;
                        last_four_match  <= 1'b0;
                        cnt              <= '0;
                        busy             <= 1'b1;
                        state            <= GET_LO;
                    end
                end
                GET_LO: begin
                    if (key_valid) begin
                        pin[3:0]   <= key_nibble;
                        req_access <= 1'b1;
                        cnt        <= '0;
                        state      <= CHECK;
                    end else if (cnt == TIMEOUT_LAST) begin
                        pin   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                CHECK: begin
                    cnt              <= '0;
                    first_four_match <= (pin[7:4] == stored_pin[7:4]);
                    last_four_match  <= (pin[3:0] == stored_pin[3:0]);
                    if (pin == stored_pin) begin
                        tries_left <= TRIES_INIT;
                        state      <= HOLD;
                    end else if (tries_left > 3'd1) begin
                        tries_left <= tries_left - 3'd1;
                        state      <= HOLD;
                    end else begin
                        // Lockout reports no match even if one nibble was right.
                        tries_left       <= '0;
                        first_four_match <= 1'b0;
                        last_four_match  <= 1'b0;
                        locked_out       <= 1'b1;
                        state            <= LOCKOUT;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt <= '0;
                        if (first_four_match && last_four_match && prog_en) begin
                            state <= PROG_HI;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                LOCKOUT: begin
                    if (cnt == LOCK_LAST) begin
                        cnt        <= '0;
                        tries_left <= TRIES_INIT;
                        locked_out <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                PROG_HI: begin
                    if (key_valid) begin
                        shadow_hi <= key_nibble;
                        cnt       <= '0;
                        state     <= PROG_LO;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                PROG_LO: begin
                    if (key_valid) begin
                        stored_pin  <= {shadow_hi, key_nibble};
                        pin_updated <= 1'b1;
                        cnt         <= '0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    cnt        <= '0;
                    busy       <= 1'b0;
                    locked_out <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pin_seq_ctrl.sv
// Directed bench for pin_seq_ctrl: a cycle-by-cycle vector table for entry
// and hold timing, then hand-written sequences for lockout, timeout, reprogramming and reset.
module tb_pin_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_nibble;
    logic       prog_en;
    logic       req_access;
    logic [7:0] pin;
    logic       first_four_match;
    logic       last_four_match;
    logic       busy;
    logic       locked_out;
    logic [2:0] tries_left;
    logic       pin_updated;
    logic [2:0] state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    pin_seq_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .key_valid        (key_valid),
        .key_nibble       (key_nibble),
        .prog_en          (prog_en),
        .req_access       (req_access),
        .pin              (pin),
        .first_four_match (first_four_match),
        .last_four_match  (last_four_match),
        .busy             (busy),
        .locked_out       (locked_out),
        .tries_left       (tries_left),
        .pin_updated      (pin_updated),
        .state_dbg        (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic       kv;
        logic [3:0] nib;
        logic       pe;
        logic       chk_pin;
        logic [7:0] pin;
        logic       req;
        logic       ffm;
        logic       lfm;
        logic       busy;
        logic       lock;
        logic [2:0] tries;
        logic       upd;
    } vec_t;

    vec_t vecs[$];

    // scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // drivers
    task automatic tick(input logic kv, input logic [3:0] nib);
        key_valid  = kv;
        key_nibble = nib;
        @(posedge clk);
        #1;
        key_valid  = 1'b0;
        key_nibble = 4'h0;
    endtask

    task automatic enter(input logic [3:0] hi, input logic [3:0] lo);
        tick(1'b1, hi);
        tick(1'b1, lo);
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (busy && i < budget) begin
            tick(1'b0, 4'h0);
            i++;
        end
        check("wait_idle.busy", busy, 0);
    endtask

    function automatic void add(input logic kv, input logic [3:0] nib, input logic chk_pin,
                                input logic [7:0] p, input logic req, input logic ffm,
                                input logic lfm, input logic bsy, input logic [2:0] tries);
        vec_t v;
        v.kv = kv; v.nib = nib; v.pe = 1'b0; v.chk_pin = chk_pin; v.pin = p;
        v.req = req; v.ffm = ffm; v.lfm = lfm; v.busy = bsy; v.lock = 1'b0;
        v.tries = tries; v.upd = 1'b0;
        vecs.push_back(v);
    endfunction

    initial begin
        int lock_cnt;
        int req_seen;

        // Correct entry A,5: one req pulse, both match, held 8 HOLD cycles with keys ignored.
        add(1, 4'hA, 1, 8'hA0, 0, 0, 0, 1, 3);
        add(1, 4'h5, 1, 8'hA5, 1, 0, 0, 1, 3);
        add(0, 4'h0, 1, 8'hA5, 0, 1, 1, 1, 3);
        for (int i = 0; i < 7; i++) add(1, 4'hF, 1, 8'hA5, 0, 1, 1, 1, 3);
        add(1, 4'h7, 1, 8'hA5, 0, 1, 1, 0, 3);
        add(0, 4'h0, 1, 8'hA5, 0, 1, 1, 0, 3);
        // Wrong entry A,3: first nibble matches, last does not, one try used.
        add(1, 4'hA, 0, 8'h00, 0, 0, 0, 1, 3);
        add(1, 4'h3, 1, 8'hA3, 1, 0, 0, 1, 3);
        add(0, 4'h0, 1, 8'hA3, 0, 1, 0, 1, 2);
        for (int i = 0; i < 7; i++) add(0, 4'h0, 1, 8'hA3, 0, 1, 0, 1, 2);
        add(0, 4'h0, 1, 8'hA3, 0, 1, 0, 0, 2);

        rst = 1'b1; key_valid = 1'b0; key_nibble = 4'h0; prog_en = 1'b0;
        tick(1'b0, 4'h0);
        tick(1'b0, 4'h0);
        check("reset.req", req_access, 0);
        check("reset.pin", pin, 8'h00);
        check("reset.ffm", first_four_match, 0);
        check("reset.lfm", last_four_match, 0);
        check("reset.busy", busy, 0);
        check("reset.locked", locked_out, 0);
        check("reset.tries", tries_left, 3);
        check("reset.upd", pin_updated, 0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            prog_en = vecs[i].pe;
            tick(vecs[i].kv, vecs[i].nib);
            if (vecs[i].chk_pin) check($sformatf("vec%0d.pin", i), pin, vecs[i].pin);
            check($sformatf("vec%0d.req", i), req_access, vecs[i].req);
            check($sformatf("vec%0d.ffm", i), first_four_match, vecs[i].ffm);
            check($sformatf("vec%0d.lfm", i), last_four_match, vecs[i].lfm);
            check($sformatf("vec%0d.busy", i), busy, vecs[i].busy);
            check($sformatf("vec%0d.locked", i), locked_out, vecs[i].lock);
            check($sformatf("vec%0d.tries", i), tries_left, vecs[i].tries);
            check($sformatf("vec%0d.upd", i), pin_updated, vecs[i].upd);
        end

        // Two more wrong entries reach lockout; keys during lockout are dropped.
        enter(4'hA, 4'h3);
        tick(1'b0, 4'h0);
        check("lock.tries_after_2nd", tries_left, 1);
        wait_idle(20);
        enter(4'hA, 4'h0);
        lock_cnt = 0;
        req_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick(i <= 16, 4'(i));
            if (i == 0) begin
                check("lock.tries_zero", tries_left, 0);
                check("lock.ffm_clear", first_four_match, 0);
                check("lock.busy", busy, 1);
            end
            if (locked_out) lock_cnt++;
            if (req_access) req_seen++;
        end
        check("lock.cycles", lock_cnt, 16);
        check("lock.req_seen", req_seen, 0);
        check("lock.tries_restored", tries_left, 3);
        check("lock.busy_after", busy, 0);
        check("lock.pin_kept", pin, 8'hA0);

        // First nibble then 32 idle cycles times out back to IDLE.
        req_seen = 0;
        tick(1'b1, 4'hA);
        for (int i = 0; i < 31; i++) begin
            tick(1'b0, 4'h0);
            if (req_access) req_seen++;
        end
        check("timeout.busy_at_31", busy, 1);
        tick(1'b0, 4'h0);
        if (req_access) req_seen++;
        check("timeout.busy_at_32", busy, 0);
        check("timeout.pin", pin, 8'h00);
        check("timeout.req_seen", req_seen, 0);
        check("timeout.tries", tries_left, 3);

        // Reprogram to 3C after a good entry with prog_en held.
        prog_en = 1'b1;
        enter(4'hA, 4'h5);
        for (int i = 0; i < 9; i++) tick(1'b0, 4'h0);
        check("prog.state_hi", state_dbg, 3'd5);
        check("prog.busy", busy, 1);
        tick(1'b1, 4'h3);
        check("prog.upd_early", pin_updated, 0);
        tick(1'b1, 4'hC);
        check("prog.upd_pulse", pin_updated, 1);
        check("prog.busy_done", busy, 0);
        tick(1'b0, 4'h0);
        check("prog.upd_one_cycle", pin_updated, 0);
        prog_en = 1'b0;
        enter(4'hA, 4'h5);
        tick(1'b0, 4'h0);
        check("prog.old_ffm", first_four_match, 0);
        check("prog.old_lfm", last_four_match, 0);
        check("prog.old_tries", tries_left, 2);
        wait_idle(20);
        enter(4'h3, 4'hC);
        tick(1'b0, 4'h0);
        check("prog.new_ffm", first_four_match, 1);
        check("prog.new_lfm", last_four_match, 1);
        check("prog.new_tries", tries_left, 3);
        wait_idle(20);

        // Reset during lockout restores tries and the default PIN.
        for (int k = 0; k < 2; k++) begin
            enter(4'h1, 4'h1);
            tick(1'b0, 4'h0);
            wait_idle(20);
        end
        enter(4'h1, 4'h1);
        tick(1'b0, 4'h0);
        check("rstlock.locked", locked_out, 1);
        for (int i = 0; i < 3; i++) tick(1'b0, 4'h0);
        rst = 1'b1;
        tick(1'b0, 4'h0);
        rst = 1'b0;
        check("rstlock.locked_clear", locked_out, 0);
        check("rstlock.tries", tries_left, 3);
        check("rstlock.busy", busy, 0);
        check("rstlock.pin", pin, 8'h00);
        enter(4'hA, 4'h5);
        tick(1'b0, 4'h0);
        check("rstlock.default_ffm", first_four_match, 1);
        check("rstlock.default_lfm", last_four_match, 1);

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pin_seq_ctrl.md
PIN_SEQ_CTRL -- requirements
Module: pin_seq_ctrl

Interface
REQ-001 Parameter MAX_TRIES, default 3, wrong entries allowed before lockout (1..7).
REQ-002 Parameter HOLD_CYC, default 8, cycles match results are held after a check.
REQ-003 Parameter LOCK_CYC, default 16, lockout duration in cycles.
REQ-004 Parameter TIMEOUT_CYC, default 32, maximum idle cycles between nibbles of one entry.
REQ-005 Parameter DEFAULT_PIN, default 8'hA5, stored PIN after reset.
REQ-006 clk  input  1  system clock, rising edge.
REQ-007 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-008 key_valid  input  1  one-cycle strobe; key_nibble valid.
REQ-009 key_nibble  input  4  keypad digit.
REQ-010 prog_en  input  1  request PIN reprogramming after a successful unlock.
REQ-011 req_access  output  1  one-cycle request pulse to the lock datapath.
REQ-012 pin  output  8  entered PIN {first nibble, second nibble}.
REQ-013 first_four_match  output  1  pin[7:4] equals stored[7:4].
REQ-014 last_four_match  output  1  pin[3:0] equals stored[3:0].
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 locked_out  output  1  high while in LOCKOUT.
REQ-017 tries_left  output  3  remaining wrong attempts.
REQ-018 pin_updated  output  1  one-cycle pulse when a new PIN is stored.

Function
REQ-019 States: IDLE, GET_LO, CHECK, HOLD, LOCKOUT, PROG_HI, PROG_LO.
REQ-020 IDLE: key_valid -> pin[7:4]=key_nibble, matches cleared, go GET_LO.
REQ-021 GET_LO: key_valid -> pin[3:0]=key_nibble, go CHECK; timeout counter restarts on entry.
REQ-022 GET_LO without key_valid for TIMEOUT_CYC consecutive cycles -> IDLE, pin=0, tries_left unchanged.
REQ-023 CHECK lasts exactly one cycle: req_access=1, matches registered from pin vs stored PIN, visible the next cycle and held through HOLD.
REQ-024 CHECK, both nibbles match -> tries_left=MAX_TRIES, go HOLD.
REQ-025 CHECK, any mismatch and tries_left>1 -> tries_left decrements, go HOLD.
REQ-026 CHECK, any mismatch and tries_left==1 -> tries_left=0, go LOCKOUT.
REQ-027 HOLD lasts HOLD_CYC cycles; key_valid ignored; at exit, if last check matched and prog_en=1 -> PROG_HI, else IDLE.
REQ-028 Leaving HOLD for IDLE keeps pin and match outputs until the next first nibble is accepted.
REQ-029 LOCKOUT lasts LOCK_CYC cycles, locked_out=1, key_valid ignored, matches=0; exit -> tries_left=MAX_TRIES, IDLE.
REQ-030 PROG_HI/PROG_LO capture two nibbles into a shadow register; on the second nibble, stored PIN is updated, pin_updated pulses one cycle, go IDLE.
REQ-031 PROG_HI/PROG_LO follow the TIMEOUT_CYC rule; a timeout returns to IDLE with stored PIN unchanged.
REQ-032 req_access pulses only in CHECK; never two consecutive cycles.
REQ-033 key_valid in the same cycle as a state change is consumed only by the current state.

Reset
REQ-034 rst in any state, including mid-entry or LOCKOUT, -> IDLE next cycle.
REQ-035 On reset: req_access=0, pin=0, first_four_match=0, last_four_match=0, busy=0, locked_out=0, pin_updated=0, tries_left=MAX_TRIES, stored PIN=DEFAULT_PIN, all counters 0.

Verification
REQ-036 Keys A,5 -> req_access one pulse, both matches=1, tries_left=3, busy for HOLD_CYC cycles, then IDLE.
REQ-037 Keys A,3 -> first_four_match=1, last_four_match=0, tries_left=2.
REQ-038 Three wrong entries -> tries_left=0, locked_out=1 for exactly 16 cycles, keys ignored; then tries_left=3.
REQ-039 Key A then 32 idle cycles -> IDLE, no req_access pulse, tries_left unchanged.
REQ-040 Keys A,5 with prog_en=1, then 3,C -> pin_updated pulse; next A,5 -> mismatch; 3,C -> both matches=1.
REQ-041 rst asserted during LOCKOUT -> next cycle locked_out=0, tries_left=3, stored PIN=8'hA5.
